hpu_palette: RTL and testbench

HPU_PALETTE -- requirements
Module: hpu_palette

---
 rtl/hpu_pkg.sv | 18 +
 rtl/hpu_palette_ram.sv | 30 +++
 rtl/hpu_palette.sv | 132 +++++++++++++
 tb/tb_hpu_palette.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/hpu_pkg.sv
// Shared HPU memory map, raster geometry and palette-fetch state encoding.
package hpu_pkg;

  localparam logic [15:0] TILE_BASE         = 16'h0000;
  localparam logic [15:0] NAMETABLE_BASE    = 16'h1800;
  localparam logic [15:0] ATTRIBUTE_BASE    = 16'h2700;
  localparam logic [15:0] PALETTE_BASE_DEF  = 16'h2ac0;
  localparam int          VIS_COLS_DEF      = 800;
  localparam int          VIS_LINES_DEF     = 480;
  localparam logic [6:0]  PALETTE_BYTES     = 7'd64;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_ISSUE = 2'd1,
    FETCH_DONE  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/hpu_palette_ram.sv
// 32 x 12-bit palette store: one synchronous write port, one asynchronous read port.
module hpu_palette_ram
  import hpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [11:0] wdata,
  input  logic [4:0]  raddr,
  output logic [11:0] rdata
);

  logic [11:0] mem_r [0:31];

  // Storage array with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mem_r[i] <= 12'h000;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write returns the old entry
  assign rdata = mem_r[raddr];

endmodule

// File: rtl/hpu_palette.sv
// Palette fetch from video memory during vertical blank plus 2-stage index-to-RGB lookup.
module hpu_palette
  import hpu_pkg::*;
#(
  parameter logic [15:0] PALETTE_BASE = PALETTE_BASE_DEF,
  parameter int          VIS_COLS     = VIS_COLS_DEF,
  parameter int          VIS_LINES    = VIS_LINES_DEF
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  true_line,
  input  logic [9:0]  true_column,
  input  logic [4:0]  tile_pixel_in,
  output logic [15:0] addr_out,
  input  logic [7:0]  data_in,
  output logic        fetch_busy,
  output logic [11:0] rgb_out,
  output logic        rgb_valid
);

  localparam logic [9:0] VIS_COLS_W  = 10'(VIS_COLS);
  localparam logic [9:0] VIS_LINES_W = 10'(VIS_LINES);

  fetch_state_e state_r, state_n;
  logic [6:0]   cnt_r, cnt_n;
  logic [15:0]  addr_r;
  logic         busy_r;
  logic [7:0]   gb_r;
  logic [4:0]   idx_r;
  logic         active_r;
  logic [11:0]  rgb_r;
  logic         valid_r;

  logic         trigger_s;
  logic         active_s;
  logic         cap_s;
  logic [6:0]   byte_idx_s;
  logic         we_s;
  logic [4:0]   rd_addr_s;
  logic [11:0]  rd_data_s;

  assign trigger_s  = (true_line == VIS_LINES_W) && (true_column == 10'd0);
  assign active_s   = (true_line < VIS_LINES_W) && (true_column < VIS_COLS_W);
  // Byte captured this cycle was addressed on the previous ISSUE cycle
  assign cap_s      = (state_r == FETCH_ISSUE) && (cnt_r != 7'd0);
  assign byte_idx_s = cnt_r - 7'd1;
  assign we_s       = cap_s && byte_idx_s[0];
  assign rd_addr_s  = (idx_r[2:0] == 3'd0) ? 5'd0 : idx_r;

  // Fetch FSM next-state and byte counter
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    case (state_r)
      FETCH_IDLE: begin
        if (trigger_s) begin
          state_n = FETCH_ISSUE;
          cnt_n   = 7'd0;
        end else begin
          state_n = FETCH_IDLE;
        end
      end
      FETCH_ISSUE: begin
        if (cnt_r == PALETTE_BYTES) begin
          state_n = FETCH_DONE;
          cnt_n   = 7'd0;
        end else begin
          cnt_n   = cnt_r + 7'd1;
        end
      end
      FETCH_DONE: begin
        state_n = FETCH_IDLE;
      end
      default: begin
        state_n = FETCH_IDLE;
        cnt_n   = 7'd0;
      end
    endcase
  end

  // Fetch state, address and even-byte holding registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH_IDLE;
      cnt_r   <= 7'd0;
      addr_r  <= 16'h0000;
      busy_r  <= 1'b0;
      gb_r    <= 8'h00;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      busy_r  <= (state_n == FETCH_ISSUE);
      if ((state_n == FETCH_ISSUE) && (cnt_n < PALETTE_BYTES)) begin
        addr_r <= PALETTE_BASE + {9'd0, cnt_n};
      end
      if (cap_s && !byte_idx_s[0]) begin
        gb_r <= data_in;
      end
    end
  end

  hpu_palette_ram u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we_s),
    .waddr (byte_idx_s[5:1]),
    .wdata ({data_in[3:0], gb_r}),
    .raddr (rd_addr_s),
    .rdata (rd_data_s)
  );

  // Two-stage pixel pipeline: index/active, then colour lookup
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r    <= 5'd0;
      active_r <= 1'b0;
      rgb_r    <= 12'h000;
      valid_r  <= 1'b0;
    end else begin
      idx_r    <= tile_pixel_in;
      active_r <= active_s;
      rgb_r    <= active_r ? rd_data_s : 12'h000;
      valid_r  <= active_r;
    end
  end

  assign addr_out   = addr_r;
  assign fetch_busy = busy_r;
  assign rgb_out    = rgb_r;
  assign rgb_valid  = valid_r;

endmodule

// File: tb/tb_hpu_palette.sv
// Directed bench for hpu_palette: reset, pixel lookup, palette fetch, blanking, abort and retrigger.
module tb_hpu_palette;

  logic        clk;
  logic        reset;
  logic [9:0]  true_line;
  logic [9:0]  true_column;
  logic [4:0]  tile_pixel_in;
  logic [15:0] addr_out;
  logic [7:0]  data_in;
  logic        fetch_busy;
  logic [11:0] rgb_out;
  logic        rgb_valid;

  logic [7:0]  mem [0:63];
  logic [15:0] mem_off;
  int          n_cmp;
  int          n_bad;

  hpu_palette dut (
    .clk           (clk),
    .reset         (reset),
    .true_line     (true_line),
    .true_column   (true_column),
    .tile_pixel_in (tile_pixel_in),
    .addr_out      (addr_out),
    .data_in       (data_in),
    .fetch_busy    (fetch_busy),
    .rgb_out       (rgb_out),
    .rgb_valid     (rgb_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Video memory model: read data one cycle after the address
  assign mem_off = addr_out - 16'h2ac0;
  always @(posedge clk) data_in <= mem[mem_off[5:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [9:0] ln, input logic [9:0] col, input logic [4:0] idx,
                        input logic [11:0] exp_rgb, input logic exp_valid, input string name);
    true_line = ln; true_column = col; tile_pixel_in = idx;
    tick(); tick();
    n_cmp++;
    if (rgb_out !== exp_rgb || rgb_valid !== exp_valid) begin
      n_bad++;
      $display("FAIL %s: rgb=%h valid=%b, required rgb=%h valid=%b", name, rgb_out, rgb_valid, exp_rgb, exp_valid);
    end
    true_line = 10'd0; true_column = 10'd0;
  endtask

  // Trigger a fetch, check every address, optionally re-pulse the trigger, count busy cycles
  task automatic do_fetch(input int retrig_at, output int busy_cnt);
    int k;
    true_line = 10'd480; true_column = 10'd0;
    tick();
    true_line = 10'd0;
    k = 0;
    while (fetch_busy === 1'b1 && k < 200) begin
      n_cmp++;
      if (addr_out !== 16'h2ac0 + 16'((k < 64) ? k : 63)) begin
        n_bad++;
        $display("FAIL fetch_addr[%0d]: got %h, required %h", k, addr_out, 16'h2ac0 + 16'((k < 64) ? k : 63));
      end
      true_line = (k == retrig_at) ? 10'd480 : 10'd0;
      k++;
      tick();
    end
    true_line = 10'd0;
    busy_cnt = k;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_cmp++;
    if (fetch_busy !== 1'b0 || addr_out !== 16'h0000 || rgb_out !== 12'h000 || rgb_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b addr=%h rgb=%h valid=%b, required 0/0000/000/0",
               fetch_busy, addr_out, rgb_out, rgb_valid);
    end
    lookup(10'd0, 10'd0, 5'h0A, 12'h000, 1'b1, "visible_after_reset");
  endtask

  task automatic test_full_fetch();
    int bc;
    for (int i = 0; i < 64; i++) mem[i] = (i % 2 == 0) ? 8'h5A : 8'hF3;
    do_fetch(-1, bc);
    n_cmp++;
    if (bc !== 65) begin n_bad++; $display("FAIL full_fetch_busy: got %0d cycles, required 65", bc); end
    lookup(10'd0, 10'd0, 5'h0A, 12'h35A, 1'b1, "full_fetch_idx0A");
    lookup(10'd0, 10'd0, 5'h1F, 12'h35A, 1'b1, "full_fetch_idx1F");
  endtask

  task automatic test_blanking();
    lookup(10'd0, 10'd800, 5'h0A, 12'h000, 1'b0, "blank_col800");
    lookup(10'd480, 10'd5, 5'h0A, 12'h000, 1'b0, "blank_line480");
    lookup(10'd479, 10'd799, 5'h0A, 12'h35A, 1'b1, "last_visible");
  endtask

  task automatic test_transparency();
    int bc;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[0] = 8'h23; mem[1] = 8'h01; mem[16] = 8'hFF; mem[17] = 8'h0F;
    do_fetch(-1, bc);
    lookup(10'd0, 10'd0, 5'h08, 12'h123, 1'b1, "transparent_idx08");
    lookup(10'd0, 10'd0, 5'h18, 12'h123, 1'b1, "transparent_idx18");
    lookup(10'd0, 10'd0, 5'h0A, 12'h000, 1'b1, "cleared_idx0A");
  endtask

  task automatic test_retrigger();
    int bc;
    do_fetch(10, bc);
    n_cmp++;
    if (bc !== 65) begin n_bad++; $display("FAIL retrig_busy: got %0d cycles, required 65", bc); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (fetch_busy !== 1'b0) begin n_bad++; $display("FAIL retrig_restart[%0d]: busy=%b, required 0", i, fetch_busy); end
      tick();
    end
  endtask

  task automatic test_reset_mid_fetch();
    true_line = 10'd480; true_column = 10'd0;
    tick();
    true_line = 10'd0;
    for (int i = 0; i < 20; i++) tick();
    n_cmp++;
    if (fetch_busy !== 1'b1 || addr_out !== 16'h2ad4) begin
      n_bad++;
      $display("FAIL midfetch_pos: busy=%b addr=%h, required 1/2ad4", fetch_busy, addr_out);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (fetch_busy !== 1'b0) begin n_bad++; $display("FAIL midfetch_abort: busy=%b, required 0", fetch_busy); end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (fetch_busy !== 1'b0 || addr_out !== 16'h0000) begin
        n_bad++;
        $display("FAIL midfetch_quiet[%0d]: busy=%b addr=%h, required 0/0000", i, fetch_busy, addr_out);
      end
    end
    for (int i = 0; i < 32; i++) lookup(10'd0, 10'd0, 5'(i), 12'h000, 1'b1, $sformatf("midfetch_entry%0d", i));
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; true_line = 10'd0; true_column = 10'd0; tile_pixel_in = 5'd0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    test_reset();
    test_full_fetch();
    test_blanking();
    test_transparency();
    test_retrigger();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
